shadow_chain: RTL and testbench

Capture-side endpoint of the ShadowCapture scan-chain protocol. On a capture strobe it snapshots a parallel state vector into a shadow register and raises `ready`. It then shifts the snapshot out LSB-first on `sout`, one bit per cycle in which the chain controller grants `en`. It raises `done` when the chain is exhausted. One instance sits beside each observed state block; its `ready`/`done`/`sout`/`en` connect to one bit of the chain controller's chains-in ready/done/data/enable buses.

---
 rtl/shadow_chain_if.sv | 24 ++
 rtl/shadow_chain.sv | 112 +++++++++++
 tb/tb_shadow_chain.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/shadow_chain_if.sv
// Bus bundle for one ShadowCapture chain endpoint.
// master: chain controller / observed block side. slave: the shadow_chain endpoint.
interface shadow_chain_if #(
   parameter int WIDTH = 32
) ();
   logic             capture;
   logic [WIDTH-1:0] din;
   logic             en;
   logic             rearm;
   logic             ready;
   logic             done;
   logic             sout;
   logic             overrun;

   modport master (
      output capture, din, en, rearm,
      input  ready, done, sout, overrun
   );

   modport slave (
      input  capture, din, en, rearm,
      output ready, done, sout, overrun
   );
endinterface

// File: rtl/shadow_chain.sv
// ShadowCapture chain endpoint: snapshots din into a shadow register on capture,
// then shifts it out LSB-first on sout, one bit per granted en cycle.
// Optional macro SHADOW_CHAIN_PARITY_EN appends an even-parity bit after the data.
module shadow_chain #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 6
) (
   input logic           clk,
   input logic           rst,
   shadow_chain_if.slave bus
);

`ifdef SHADOW_CHAIN_PARITY_EN
   localparam int L = WIDTH + 1;
`else
   localparam int L = WIDTH;
`endif

   typedef enum logic [1:0] {S_IDLE, S_READY, S_SHIFT, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [L-1:0]         shreg_q, shreg_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 overrun_q, overrun_d;
   logic                 ready_q, ready_d;
   logic                 done_q, done_d;
   logic                 sout_q, sout_d;
   logic [L-1:0]         load_val;

`ifdef SHADOW_CHAIN_PARITY_EN
   assign load_val = {^bus.din, bus.din};
`else
   assign load_val = bus.din;
`endif

   // Next-state decode; outputs are decoded from the next state so they leave a flop.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      overrun_d = overrun_q;
      unique case (state_q)
         S_IDLE: begin
            // rearm here is a no-op, so a same-cycle capture is still taken
            if (bus.capture) begin
               shreg_d = load_val;
               cnt_d   = '0;
               state_d = S_READY;
            end
         end
         S_READY, S_SHIFT: begin
            if (bus.rearm) begin
               // rearm wins; a simultaneous capture is dropped without flagging
               state_d   = S_IDLE;
               overrun_d = 1'b0;
            end else begin
               if (bus.capture) overrun_d = 1'b1;
               if (bus.en) begin
                  shreg_d = shreg_q >> 1;
                  cnt_d   = cnt_q + CNT_WIDTH'(1);
                  state_d = (cnt_q == CNT_WIDTH'(L - 1)) ? S_DONE : S_SHIFT;
               end
            end
         end
         S_DONE: begin
            if (bus.rearm) begin
               overrun_d = 1'b0;
               if (bus.capture) begin
                  shreg_d = load_val;
                  cnt_d   = '0;
                  state_d = S_READY;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (bus.capture) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_READY) || (state_d == S_SHIFT);
      done_d  = (state_d == S_DONE);
      sout_d  = ready_d & shreg_d[0];
   end

   // State, shadow data, counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
         sout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         sout_q    <= sout_d;
      end
   end

   assign bus.ready   = ready_q;
   assign bus.done    = done_q;
   assign bus.sout    = sout_q;
   assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_shadow_chain.sv
// Bench for shadow_chain: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_shadow_chain;
`ifdef SHADOW_CHAIN_PARITY_EN
   localparam int L = 9;
`else
   localparam int L = 8;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   bit   mon_on = 1'b0;

   shadow_chain_if #(.WIDTH(8)) bus ();

   shadow_chain #(.WIDTH(8), .CNT_WIDTH(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // reference model: 0 = idle, 1 = snapshot held, 2 = exhausted
   int mmode = 0;
   bit mbits[$];
   bit movr = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mmode = 0;
      mbits.delete();
      movr = 1'b0;
   endtask

   task automatic model_load(input logic [7:0] d);
      mbits.delete();
      for (int i = 0; i < 8; i++) mbits.push_back(d[i]);
`ifdef SHADOW_CHAIN_PARITY_EN
      mbits.push_back(^d);
`endif
      mmode = 1;
   endtask

   task automatic model_edge(input bit c, input logic [7:0] d, input bit e, input bit r);
      case (mmode)
         0: if (c) model_load(d);
         1: begin
            if (r) begin
               mmode = 0;
               movr  = 1'b0;
            end else begin
               if (c) movr = 1'b1;
               if (e) begin
                  void'(mbits.pop_front());
                  if (mbits.size() == 0) mmode = 2;
               end
            end
         end
         default: begin
            if (r) begin
               movr = 1'b0;
               if (c) model_load(d);
               else mmode = 0;
            end else if (c) begin
               movr = 1'b1;
            end
         end
      endcase
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (mon_on && !rst) begin
         chk("m_ready", bus.ready, (mmode == 1));
         chk("m_done", bus.done, (mmode == 2));
         chk("m_sout", bus.sout, (mmode == 1 && mbits.size() > 0) ? mbits[0] : 1'b0);
         chk("m_overrun", bus.overrun, movr);
      end
   end

   // one clock: drive inputs at negedge, advance model at posedge, return at next negedge
   task automatic step(input bit c, input logic [7:0] d, input bit e, input bit r);
      bus.capture = c;
      bus.din     = d;
      bus.en      = e;
      bus.rearm   = r;
      @(posedge clk);
      model_edge(c, d, e, r);
      @(negedge clk);
   endtask

   task automatic do_rst();
      bus.capture = 1'b0;
      bus.en      = 1'b0;
      bus.rearm   = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_ready", bus.ready, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_sout", bus.sout, 0);
      chk("rst_overrun", bus.overrun, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // shift until done (bounded); optional pause at bit index and capture pulse at bit index
   task automatic drain(input int pause_at, input int pause_len, input bit pause_val,
                        input int cap_at, output int cyc, output logic [8:0] seq);
      int k = 0;
      int p = 0;
      cyc = 0;
      seq = '0;
      while (!bus.done && cyc < 60) begin
         if (k == pause_at && p < pause_len) begin
            chk("pause_hold", bus.sout, pause_val);
            step(1'b0, 8'h00, 1'b0, 1'b0);
            p++;
         end else begin
            if (k < 9) seq[k] = bus.sout;
            step(k == cap_at, 8'hFF, 1'b1, 1'b0);
            k++;
         end
         cyc++;
      end
   endtask

   initial begin
      int         cyc;
      logic [8:0] seq;
      bus.capture = 1'b0;
      bus.din     = '0;
      bus.en      = 1'b0;
      bus.rearm   = 1'b0;
      @(negedge clk);
      do_rst();
      mon_on = 1'b1;

      // continuous shift of 0xA5
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      chk("a5_first_sout", bus.sout, 1);
      drain(-1, 0, 1'b0, -1, cyc, seq);
      chk("a5_cycles", cyc, L);
      chk("a5_seq", seq, 9'h0A5);
      chk("a5_ready_end", bus.ready, 0);
      chk("a5_done_end", bus.done, 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // en low for 3 cycles after bit 2 has been presented
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      drain(2, 3, 1'b1, -1, cyc, seq);
      chk("pause_cycles", cyc, L + 3);
      chk("pause_seq", seq, 9'h0A5);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // capture during SHIFT is ignored for data but flags overrun
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      drain(-1, 0, 1'b0, 3, cyc, seq);
      chk("ovr_seq", seq, 9'h03C);
      chk("ovr_flag", bus.overrun, 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovr_cleared", bus.overrun, 0);
      chk("ovr_idle_ready", bus.ready, 0);

      // reset after 4 bits, then 0x81
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      do_rst();
      step(1'b1, 8'h81, 1'b0, 1'b0);
      drain(-1, 0, 1'b0, -1, cyc, seq);
      chk("x81_seq", seq, 9'h081);
      chk("x81_cycles", cyc, L);

      // in DONE: capture alone flags overrun; rearm+capture reloads directly
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("done_cap_ovr", bus.overrun, 1);
      step(1'b1, 8'h5A, 1'b0, 1'b1);
      chk("rc_ready", bus.ready, 1);
      chk("rc_done", bus.done, 0);
      chk("rc_sout", bus.sout, 0);
      chk("rc_overrun", bus.overrun, 0);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // 0x01: parity bit is 1 when enabled
      step(1'b1, 8'h01, 1'b0, 1'b0);
      drain(-1, 0, 1'b0, -1, cyc, seq);
`ifdef SHADOW_CHAIN_PARITY_EN
      chk("x01_seq", seq, 9'h101);
`else
      chk("x01_seq", seq, 9'h001);
`endif
      chk("x01_cycles", cyc, L);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_rst();
         end else begin
            step($urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0);
         end
      end

      mon_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
